frogger_hit_manager: RTL
========================

// Module: frogger_hit_manager
// PURPOSE
//  Parametrised collision and lives controller for N cars of configurable length.
//  Registers frog/car overlap and decrements lives once per hit.
//  Sequences respawn handshake, post-respawn invulnerability and game-over.
//  Sits between car movers / frog controller and score/display logic.
// PARAMETERS
//  NUM_CARS       5   number of car channels
//  COORD_W        6   coordinate width (X and Y)
//  CAR_LEN        2   car length in tiles along X, >=1
//  FROG_LEN       2   frog length in tiles along X, >=1
//  LIVES_W        2   lives counter width
//  START_LIVES    3   lives loaded at reset / restart, <= 2^LIVES_W-1
//  INVULN_CYCLES  8   cycles of collision immunity after respawn; 0 = none
// PORTS
//  i_Clk           in   1                  system clock
//  i_Reset         in   1                  synchronous, active-high reset
//  i_Frogger_X     in   COORD_W            frog X (left tile)
//  i_Frogger_Y     in   COORD_W            frog Y
//  i_Car_X         in   NUM_CARS*COORD_W   car k X at [k*COORD_W +: COORD_W]
//  i_Car_Y         in   NUM_CARS*COORD_W   car k Y, same packing
//  i_Respawn_Done  in   1                  frog controller has returned frog to origin
//  i_Game_Start    in   1                  restart request
//  o_Lives         out  LIVES_W            remaining lives
//  o_Hit           out  1                  1-cycle pulse per accepted hit
//  o_Hit_Index     out  clog2(NUM_CARS)    car index of last accepted hit
//  o_Respawn_Req   out  1                  level, high until i_Respawn_Done
//  o_Invuln        out  1                  high while in INVULN
//  o_Game_Over     out  1                  high while in GAME_OVER
// BEHAVIOUR
//  - Reset: state PLAY, o_Lives=START_LIVES, all other outputs 0; dominates all inputs.
//  - Overlap car k: Y equal AND car_x <= frog_x+FROG_LEN-1 AND frog_x <= car_x+CAR_LEN-1,
//    computed in COORD_W+1 bits (no wrap; tiles past 2^COORD_W-1 do not exist).
//  - Overlap vector registered each cycle (r_Hit_Vec); decisions use r_Hit_Vec -> 1-cycle latency.
//  - Priority: lowest-index overlapping car drives o_Hit_Index.
//  - States:
//    PLAY: r_Hit_Vec!=0 -> o_Hit=1 next cycle, o_Lives-1, latch index;
//          lives after decrement >0 -> RESPAWN, ==0 -> GAME_OVER.
//    RESPAWN: o_Respawn_Req=1; overlaps ignored; i_Respawn_Done -> INVULN
//          (INVULN_CYCLES=0 -> PLAY directly, overlap vector cleared that cycle).
//    INVULN: counter loads INVULN_CYCLES-1, decrements; overlaps ignored; at 0 -> PLAY.
//    GAME_OVER: o_Game_Over=1, lives stay 0, overlaps ignored.
//  - i_Game_Start in any state (below reset): lives=START_LIVES, counter cleared, -> PLAY,
//    o_Respawn_Req/o_Invuln/o_Game_Over drop next cycle; coincident hit discarded.
//  - Lives never underflow; one hit = one decrement regardless of cars overlapping.
//  - Continuous overlap is single hit: PLAY is left on the hit cycle.
//  - i_Respawn_Done outside RESPAWN ignored.
// STRUCTURE
//  - frogger_pkg: state encoding (PLAY, RESPAWN, INVULN, GAME_OVER), clog2 function.
//  - Sub-module frogger_overlap_detect: combinational single-car comparator,
//    instantiated NUM_CARS times via generate; priority encoder and FSM in top.
// TESTING
//  1 Reset, frog (10,5), car0 (11,5) held -> o_Hit pulse cycle 2, index 0, lives 3->2, Respawn_Req=1.
//  2 Car0 (9,5), car3 (10,5), frog (10,5) -> single hit, index 0, lives -1 only.
//  3 Frog (10,5), car (12,5) / (8,5) -> no hit (edge of CAR_LEN=2, FROG_LEN=2).
//  4 Respawn_Done then overlap during 8 INVULN cycles -> no hit; overlap on cycle 9 -> hit.
//  5 Three hits from START_LIVES=3 -> lives 0, Game_Over=1, further overlap no o_Hit;
//    i_Game_Start -> lives 3, PLAY.
//  6 i_Reset asserted mid-RESPAWN -> next cycle PLAY, lives 3, Respawn_Req=0.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and helpers for the frogger hit manager.
package frogger_pkg;

  typedef enum logic [1:0] {
    StPlay,
    StRespawn,
    StInvuln,
    StGameOver
  } state_e;

  // Ceiling log2, never less than 1 so that single-entry ranges still get a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r++;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/frogger_hit_manager_if.sv
// Bus between car movers / frog controller and the hit manager, plus status outputs.
interface frogger_hit_manager_if
  import frogger_pkg::*;
#(
  parameter int unsigned NUM_CARS = 5,
  parameter int unsigned COORD_W  = 6,
  parameter int unsigned LIVES_W  = 2
);

  localparam int unsigned IdxW = clog2(NUM_CARS);

  logic [COORD_W-1:0]          i_Frogger_X;
  logic [COORD_W-1:0]          i_Frogger_Y;
  logic [NUM_CARS*COORD_W-1:0] i_Car_X;
  logic [NUM_CARS*COORD_W-1:0] i_Car_Y;
  logic                        i_Respawn_Done;
  logic                        i_Game_Start;
  logic [LIVES_W-1:0]          o_Lives;
  logic                        o_Hit;
  logic [IdxW-1:0]             o_Hit_Index;
  logic                        o_Respawn_Req;
  logic                        o_Invuln;
  logic                        o_Game_Over;

  modport master (
    output i_Frogger_X, i_Frogger_Y, i_Car_X, i_Car_Y, i_Respawn_Done, i_Game_Start,
    input  o_Lives, o_Hit, o_Hit_Index, o_Respawn_Req, o_Invuln, o_Game_Over
  );

  modport slave (
    input  i_Frogger_X, i_Frogger_Y, i_Car_X, i_Car_Y, i_Respawn_Done, i_Game_Start,
    output o_Lives, o_Hit, o_Hit_Index, o_Respawn_Req, o_Invuln, o_Game_Over
  );

endinterface

// File: rtl/frogger_overlap_detect.sv
// Combinational frog/car overlap test for a single car channel.
module frogger_overlap_detect #(
  parameter int unsigned COORD_W  = 6,
  parameter int unsigned CAR_LEN  = 2,
  parameter int unsigned FROG_LEN = 2
) (
  input  logic [COORD_W-1:0] frog_x_i,
  input  logic [COORD_W-1:0] frog_y_i,
  input  logic [COORD_W-1:0] car_x_i,
  input  logic [COORD_W-1:0] car_y_i,
  output logic               overlap_o
);

  // One extra bit so a span reaching past the last tile never wraps to column 0.
  logic [COORD_W:0] frog_lo, frog_hi, car_lo, car_hi;

  always_comb begin
    frog_lo   = {1'b0, frog_x_i};
    car_lo    = {1'b0, car_x_i};
    frog_hi   = frog_lo + (COORD_W + 1)'(FROG_LEN - 1);
    car_hi    = car_lo + (COORD_W + 1)'(CAR_LEN - 1);
    overlap_o = (frog_y_i == car_y_i) && (car_lo <= frog_hi) && (frog_lo <= car_hi);
  end

endmodule

// File: rtl/frogger_hit_manager.sv
// Collision and lives controller: registers overlaps, counts hits, sequences respawn,
// invulnerability and game-over.
module frogger_hit_manager
  import frogger_pkg::*;
#(
  parameter int unsigned NUM_CARS      = 5,
  parameter int unsigned COORD_W       = 6,
  parameter int unsigned CAR_LEN       = 2,
  parameter int unsigned FROG_LEN      = 2,
  parameter int unsigned LIVES_W       = 2,
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned INVULN_CYCLES = 8
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  frogger_hit_manager_if.slave  bus
);

  localparam int unsigned IdxW = clog2(NUM_CARS);
  localparam int unsigned CntW = clog2(INVULN_CYCLES + 1);
  localparam logic [LIVES_W-1:0] StartLives = LIVES_W'(START_LIVES);
  localparam logic [CntW-1:0] InvulnLoad =
      (INVULN_CYCLES == 0) ? '0 : CntW'(INVULN_CYCLES - 1);

  logic [NUM_CARS-1:0] overlap;
  logic [IdxW-1:0]     hit_idx;

  state_e              state_d, state_q;
  logic [NUM_CARS-1:0] hit_vec_d, hit_vec_q;
  logic [LIVES_W-1:0]  lives_d, lives_q;
  logic [CntW-1:0]     cnt_d, cnt_q;
  logic                hit_d, hit_q;
  logic [IdxW-1:0]     idx_d, idx_q;
  logic                req_d, req_q;
  logic                inv_d, inv_q;
  logic                go_d, go_q;

  for (genvar k = 0; k < NUM_CARS; k++) begin : g_car
    frogger_overlap_detect #(
      .COORD_W  (COORD_W),
      .CAR_LEN  (CAR_LEN),
      .FROG_LEN (FROG_LEN)
    ) u_detect (
      .frog_x_i  (bus.i_Frogger_X),
      .frog_y_i  (bus.i_Frogger_Y),
      .car_x_i   (bus.i_Car_X[k*COORD_W +: COORD_W]),
      .car_y_i   (bus.i_Car_Y[k*COORD_W +: COORD_W]),
      .overlap_o (overlap[k])
    );
  end

  // Scan downward so the lowest overlapping index wins.
  always_comb begin
    hit_idx = '0;
    for (int k = NUM_CARS - 1; k >= 0; k--) begin
      if (hit_vec_q[k]) begin
        hit_idx = IdxW'(k);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hit_vec_d = overlap;
    lives_d   = lives_q;
    cnt_d     = cnt_q;
    hit_d     = 1'b0;
    idx_d     = idx_q;
    req_d     = req_q;
    inv_d     = inv_q;
    go_d      = go_q;

    if (bus.i_Game_Start) begin
      state_d = StPlay;
      lives_d = StartLives;
      cnt_d   = '0;
      req_d   = 1'b0;
      inv_d   = 1'b0;
      go_d    = 1'b0;
    end else begin
      unique case (state_q)
        StPlay: begin
          if (|hit_vec_q) begin
            hit_d = 1'b1;
            idx_d = hit_idx;
            if (lives_q > LIVES_W'(1)) begin
              lives_d = lives_q - 1'b1;
              state_d = StRespawn;
              req_d   = 1'b1;
            end else begin
              lives_d = '0;
              state_d = StGameOver;
              go_d    = 1'b1;
            end
          end
        end
        StRespawn: begin
          if (bus.i_Respawn_Done) begin
            req_d = 1'b0;
            if (INVULN_CYCLES == 0) begin
              // Drop any overlap sampled while respawning so it cannot score on entry.
              state_d   = StPlay;
              hit_vec_d = '0;
            end else begin
              state_d = StInvuln;
              cnt_d   = InvulnLoad;
              inv_d   = 1'b1;
            end
          end
        end
        StInvuln: begin
          if (cnt_q == '0) begin
            state_d = StPlay;
            inv_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StGameOver: begin
          lives_d = '0;
        end
        default: begin
          state_d = StPlay;
        end
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= StPlay;
      hit_vec_q <= '0;
      lives_q   <= StartLives;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      req_q     <= 1'b0;
      inv_q     <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hit_vec_q <= hit_vec_d;
      lives_q   <= lives_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
      req_q     <= req_d;
      inv_q     <= inv_d;
      go_q      <= go_d;
    end
  end

  assign bus.o_Lives       = lives_q;
  assign bus.o_Hit         = hit_q;
  assign bus.o_Hit_Index   = idx_q;
  assign bus.o_Respawn_Req = req_q;
  assign bus.o_Invuln      = inv_q;
  assign bus.o_Game_Over   = go_q;

endmodule
